// File: rtl/zbt_access_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : zbt_access_arbiter
// Brief   : Slot-based video/audio arbiter for one ZBT SRAM port, with idle
//           gap cycles between owners. Macro ZBT_ARB_AUDIO_URGENT_EN lets a
//           starving audio client win ties and preempt video mid-slot.
// Rev     : 1.0
// ============================================================================
module zbt_access_arbiter #(
    parameter int SLOT_LEN = 16,
    parameter int GAP_LEN  = 2
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        Video_Req_I,
    input  logic        Audio_Req_I,
    input  logic        Audio_Urgent_I,
    output logic        Video_ZBT_Access_O,
    output logic        Audio_ZBT_Access_O,
    input  logic [18:0] Video_ZBT_Address_I,
    input  logic [31:0] Video_ZBT_Write_Data_I,
    input  logic        Video_ZBT_Write_En_I,
    input  logic [18:0] Audio_ZBT_Address_I,
    input  logic [31:0] Audio_ZBT_Write_Data_I,
    input  logic        Audio_ZBT_Write_En_I,
    output logic [18:0] ZBT_Address_O,
    output logic [31:0] ZBT_Write_Data_O,
    output logic        ZBT_Write_En_O,
    output logic [1:0]  Owner_O
);
    localparam int CNT_MAX = (SLOT_LEN > GAP_LEN) ? SLOT_LEN : GAP_LEN;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] SLOT_RELOAD = CNT_W'(SLOT_LEN - 1);
    localparam logic [CNT_W-1:0] GAP_RELOAD  = CNT_W'(GAP_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        GRANT_VID = 2'b01,
        GRANT_AUD = 2'b10,
        GAP       = 2'b11
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last_aud_q, last_aud_d;
    logic             vid_acc_q, vid_acc_d;
    logic             aud_acc_q, aud_acc_d;
    logic [1:0]       owner_q, owner_d;
    logic             audio_urgent;
    logic             vid_preempt;
    logic             pick_vid, pick_aud;

`ifdef ZBT_ARB_AUDIO_URGENT_EN
    localparam logic [CNT_W-1:0] HALF_SLOT = CNT_W'(SLOT_LEN / 2);
    assign audio_urgent = Audio_Req_I & Audio_Urgent_I;
    // cnt_q <= SLOT_LEN/2 means at least SLOT_LEN/2 grant cycles have elapsed
    assign vid_preempt  = audio_urgent & (cnt_q <= HALF_SLOT);
`else
    logic unused_urgent;
    assign unused_urgent = Audio_Urgent_I;
    assign audio_urgent  = 1'b0;
    assign vid_preempt   = 1'b0;
`endif

    always_comb begin
        pick_vid = 1'b0;
        pick_aud = 1'b0;
        if (audio_urgent) begin
            pick_aud = 1'b1;
        end else if (Video_Req_I && Audio_Req_I) begin
            pick_vid = last_aud_q;
            pick_aud = !last_aud_q;
        end else begin
            pick_vid = Video_Req_I;
            pick_aud = Audio_Req_I;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        last_aud_d = last_aud_q;
        case (state_q)
            IDLE, GAP: begin
                if (state_q == GAP && cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_ONE;
                end else if (pick_vid) begin
                    state_d = GRANT_VID;
                    cnt_d   = SLOT_RELOAD;
                end else if (pick_aud) begin
                    state_d = GRANT_AUD;
                    cnt_d   = SLOT_RELOAD;
                end else begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            GRANT_VID: begin
                cnt_d = cnt_q - CNT_ONE;
                if (!Video_Req_I || vid_preempt || (cnt_q == '0 && Audio_Req_I)) begin
                    state_d    = GAP;
                    cnt_d      = GAP_RELOAD;
                    last_aud_d = 1'b0;
                end else if (cnt_q == '0) begin
                    cnt_d = SLOT_RELOAD;
                end
            end
            GRANT_AUD: begin
                cnt_d = cnt_q - CNT_ONE;
                if (!Audio_Req_I || (cnt_q == '0 && Video_Req_I)) begin
                    state_d    = GAP;
                    cnt_d      = GAP_RELOAD;
                    last_aud_d = 1'b1;
                end else if (cnt_q == '0) begin
                    cnt_d = SLOT_RELOAD;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs decoded from the next state so they are flops aligned with state_q
    always_comb begin
        vid_acc_d = (state_d == GRANT_VID);
        aud_acc_d = (state_d == GRANT_AUD);
        case (state_d)
            GRANT_VID: owner_d = 2'b01;
            GRANT_AUD: owner_d = 2'b10;
            GAP:       owner_d = owner_q;
            default:   owner_d = 2'b00;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            last_aud_q <= 1'b1;
            vid_acc_q  <= 1'b0;
            aud_acc_q  <= 1'b0;
            owner_q    <= 2'b00;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            last_aud_q <= last_aud_d;
            vid_acc_q  <= vid_acc_d;
            aud_acc_q  <= aud_acc_d;
            owner_q    <= owner_d;
        end
    end

    always_comb begin
        ZBT_Address_O    = '0;
        ZBT_Write_Data_O = '0;
        ZBT_Write_En_O   = 1'b0;
        case (owner_q)
            2'b01: begin
                ZBT_Address_O    = Video_ZBT_Address_I;
                ZBT_Write_Data_O = Video_ZBT_Write_Data_I;
                ZBT_Write_En_O   = Video_ZBT_Write_En_I & vid_acc_q;
            end
            2'b10: begin
                ZBT_Address_O    = Audio_ZBT_Address_I;
                ZBT_Write_Data_O = Audio_ZBT_Write_Data_I;
                ZBT_Write_En_O   = Audio_ZBT_Write_En_I & aud_acc_q;
            end
            default: begin
                ZBT_Address_O    = '0;
                ZBT_Write_Data_O = '0;
                ZBT_Write_En_O   = 1'b0;
            end
        endcase
    end

    assign Video_ZBT_Access_O = vid_acc_q;
    assign Audio_ZBT_Access_O = aud_acc_q;
    assign Owner_O            = owner_q;

endmodule
`default_nettype wire

// File: tb/tb_zbt_access_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_zbt_access_arbiter
// Brief   : Randomized and directed bench for zbt_access_arbiter against a
//           slot/gap reference model. Honors ZBT_ARB_AUDIO_URGENT_EN.
// Rev     : 1.0
// ============================================================================
module tb_zbt_access_arbiter;
    localparam int SLOT = 16;
    localparam int GAPL = 2;
`ifdef ZBT_ARB_AUDIO_URGENT_EN
    localparam bit URG_EN = 1'b1;
`else
    localparam bit URG_EN = 1'b0;
`endif

    logic        clock  = 1'b0;
    logic        resetn = 1'b0;
    logic        vreq = 0, areq = 0, urg = 0, vwe = 0, awe = 0;
    logic [18:0] vaddr = '0, aaddr = '0;
    logic [31:0] vdata = '0, adata = '0;
    logic        va, aa, zwe;
    logic [18:0] zaddr;
    logic [31:0] zdata;
    logic [1:0]  owner;
    logic [55:0] dut_out;

    int total = 0;
    int bad   = 0;

    // Model: m_own = current/last grantee (0 none, 1 video, 2 audio),
    // m_el = grant cycles elapsed in this slot, m_gel = gap cycles elapsed.
    int m_own, m_gap, m_el, m_gel, m_last;

    always #5 clock = ~clock;

    zbt_access_arbiter #(.SLOT_LEN(SLOT), .GAP_LEN(GAPL)) dut (
        .clock                 (clock),
        .resetn                (resetn),
        .Video_Req_I           (vreq),
        .Audio_Req_I           (areq),
        .Audio_Urgent_I        (urg),
        .Video_ZBT_Access_O    (va),
        .Audio_ZBT_Access_O    (aa),
        .Video_ZBT_Address_I   (vaddr),
        .Video_ZBT_Write_Data_I(vdata),
        .Video_ZBT_Write_En_I  (vwe),
        .Audio_ZBT_Address_I   (aaddr),
        .Audio_ZBT_Write_Data_I(adata),
        .Audio_ZBT_Write_En_I  (awe),
        .ZBT_Address_O         (zaddr),
        .ZBT_Write_Data_O      (zdata),
        .ZBT_Write_En_O        (zwe),
        .Owner_O               (owner)
    );

    assign dut_out = {va, aa, owner, zwe, zaddr, zdata};

    task automatic model_reset();
        m_own = 0; m_gap = 0; m_el = 0; m_gel = 0; m_last = 2;
    endtask

    function automatic int pick();
        if (URG_EN && areq && urg) return 2;
        if (vreq && areq) return (m_last == 2) ? 1 : 2;
        if (vreq) return 1;
        if (areq) return 2;
        return 0;
    endfunction

    task automatic model_step();
        int  w;
        bit  mine, other, leave;
        if (m_own == 0 || (m_gap != 0 && m_gel == GAPL)) begin
            w = pick();
            m_gap = 0;
            m_own = w;
            m_el  = 1;
        end else if (m_gap != 0) begin
            m_gel++;
        end else begin
            mine  = (m_own == 1) ? vreq : areq;
            other = (m_own == 1) ? areq : vreq;
            leave = !mine || (m_el == SLOT && other);
            if (URG_EN && m_own == 1 && areq && urg && m_el >= SLOT / 2) leave = 1;
            if (leave) begin
                m_last = m_own;
                m_gap  = 1;
                m_gel  = 1;
            end else if (m_el == SLOT) begin
                m_el = 1;
            end else begin
                m_el++;
            end
        end
    endtask

    function automatic logic [55:0] model_out();
        logic e_va, e_aa, e_we;
        logic [1:0]  e_ow;
        logic [18:0] e_ad;
        logic [31:0] e_dt;
        e_va = (m_own == 1) && (m_gap == 0);
        e_aa = (m_own == 2) && (m_gap == 0);
        e_ow = (m_own == 1) ? 2'b01 : (m_own == 2) ? 2'b10 : 2'b00;
        e_ad = '0; e_dt = '0; e_we = 1'b0;
        if (m_own == 1) begin
            e_ad = vaddr; e_dt = vdata; e_we = vwe & e_va;
        end else if (m_own == 2) begin
            e_ad = aaddr; e_dt = adata; e_we = awe & e_aa;
        end
        return {e_va, e_aa, e_ow, e_we, e_ad, e_dt};
    endfunction

    task automatic tick();
        @(posedge clock);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        vreq = 0; areq = 0; urg = 0; vwe = 0; awe = 0;
        @(negedge clock);
        resetn = 1'b0;
        model_reset();
        @(negedge clock);
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        vreq = 1; areq = 1; urg = 1; vwe = 1; awe = 1;
        vaddr = 19'h7FFFF; aaddr = 19'h12345; vdata = 32'hDEADBEEF; adata = 32'hCAFEF00D;
        model_reset();
        #2;
        total++;
        if (dut_out !== 56'd0) begin
            bad++; $display("FAIL reset_state got=%h exp=%h", dut_out, 56'd0);
        end
        @(posedge clock); #1;
        total++;
        if (dut_out !== 56'd0) begin
            bad++; $display("FAIL reset_hold got=%h exp=%h", dut_out, 56'd0);
        end
        @(negedge clock);
        resetn = 1'b1;
    endtask

    task automatic test_video_only();
        int drops = 0;
        do_reset();
        vreq = 1;
        for (int i = 1; i <= 40; i++) begin
            vaddr = 19'($urandom()); vdata = $urandom(); vwe = 1'($urandom());
            tick();
            total++;
            if (dut_out !== model_out()) begin
                bad++; $display("FAIL video_only cyc=%0d got=%h exp=%h", i, dut_out, model_out());
            end
            if (va !== 1'b1) drops++;
        end
        total++;
        if (drops != 0) begin
            bad++; $display("FAIL video_only_continuous drops=%0d exp=0", drops);
        end
    endtask

    task automatic test_round_robin();
        int vcnt = 0, acnt = 0, ovl = 0;
        do_reset();
        vreq = 1; areq = 1;
        for (int i = 1; i <= 72; i++) begin
            tick();
            total++;
            if (dut_out !== model_out()) begin
                bad++; $display("FAIL round_robin cyc=%0d got=%h exp=%h", i, dut_out, model_out());
            end
            if (i <= 36) begin
                if (va === 1'b1) vcnt++;
                if (aa === 1'b1) acnt++;
            end
            if (va === 1'b1 && aa === 1'b1) ovl++;
        end
        total++;
        if (vcnt != 16 || acnt != 16 || ovl != 0) begin
            bad++; $display("FAIL round_robin_counts v=%0d a=%0d ovl=%0d exp=16/16/0", vcnt, acnt, ovl);
        end
    endtask

    task automatic test_early_release();
        do_reset();
        vreq = 1;
        for (int i = 1; i <= 32; i++) begin
            areq = (i < 24);
            tick();
            total++;
            if (dut_out !== model_out()) begin
                bad++; $display("FAIL early_release cyc=%0d got=%h exp=%h", i, dut_out, model_out());
            end
            if (i == 23) begin
                total++;
                if (aa !== 1'b1) begin
                    bad++; $display("FAIL early_release_c5 aud=%b exp=1", aa);
                end
            end
            if (i == 24) begin
                total++;
                if ({aa, owner} !== 3'b010) begin
                    bad++; $display("FAIL early_release_gap got=%b exp=010", {aa, owner});
                end
            end
            if (i == 26) begin
                total++;
                if ({va, aa} !== 2'b10) begin
                    bad++; $display("FAIL early_release_next got=%b exp=10", {va, aa});
                end
            end
        end
    endtask

    task automatic test_urgent();
        do_reset();
        vreq = 1;
        for (int i = 1; i <= 30; i++) begin
            areq = (i >= 4);
            urg  = (i >= 4);
            tick();
            total++;
            if (dut_out !== model_out()) begin
                bad++; $display("FAIL urgent cyc=%0d got=%h exp=%h", i, dut_out, model_out());
            end
            if (i == 9) begin
                total++;
                if (va !== !URG_EN) begin
                    bad++; $display("FAIL urgent_vid_c9 got=%b exp=%b", va, !URG_EN);
                end
            end
            if (i == 11) begin
                total++;
                if (aa !== URG_EN) begin
                    bad++; $display("FAIL urgent_aud_c11 got=%b exp=%b", aa, URG_EN);
                end
            end
            if (i == 16) begin
                total++;
                if (va !== !URG_EN) begin
                    bad++; $display("FAIL urgent_vid_c16 got=%b exp=%b", va, !URG_EN);
                end
            end
        end
        urg = 0;
    endtask

    task automatic test_write_gating();
        do_reset();
        vreq = 1; vwe = 1; vaddr = 19'h7FFFF; vdata = 32'hA5A5_5A5A;
        tick();
        total++;
        if ({zaddr, zwe} !== {19'h7FFFF, 1'b1}) begin
            bad++; $display("FAIL wr_grant addr=%h we=%b exp=7ffff/1", zaddr, zwe);
        end
        vreq = 0;
        tick();
        total++;
        if ({owner, zaddr, zwe} !== {2'b01, 19'h7FFFF, 1'b0}) begin
            bad++; $display("FAIL wr_gap own=%b addr=%h we=%b exp=01/7ffff/0", owner, zaddr, zwe);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            total++;
            if (dut_out !== model_out()) begin
                bad++; $display("FAIL wr_tail cyc=%0d got=%h exp=%h", i, dut_out, model_out());
            end
        end
        total++;
        if ({owner, zaddr, zdata, zwe} !== 54'd0) begin
            bad++; $display("FAIL wr_idle own=%b addr=%h data=%h we=%b exp=0", owner, zaddr, zdata, zwe);
        end
        vwe = 0;
    endtask

    task automatic test_mid_grant_reset();
        do_reset();
        vreq = 1; areq = 1;
        for (int i = 1; i <= 7; i++) begin
            tick();
            total++;
            if (dut_out !== model_out()) begin
                bad++; $display("FAIL midrst_pre cyc=%0d got=%h exp=%h", i, dut_out, model_out());
            end
        end
        #1 resetn = 1'b0;
        model_reset();
        #1;
        total++;
        if (dut_out !== 56'd0) begin
            bad++; $display("FAIL midrst_async got=%h exp=%h", dut_out, 56'd0);
        end
        @(negedge clock);
        resetn = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            total++;
            if (dut_out !== model_out()) begin
                bad++; $display("FAIL midrst_post cyc=%0d got=%h exp=%h", i, dut_out, model_out());
            end
            if (i == 1) begin
                total++;
                if ({va, aa} !== 2'b10) begin
                    bad++; $display("FAIL midrst_tie got=%b exp=10", {va, aa});
                end
            end
        end
    endtask

    task automatic test_random();
        int ovl = 0;
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 11) == 0) vreq = ~vreq;
            if ($urandom_range(0, 11) == 0) areq = ~areq;
            urg   = ($urandom_range(0, 5) == 0);
            vwe   = 1'($urandom()); awe = 1'($urandom());
            vaddr = 19'($urandom()); aaddr = 19'($urandom());
            vdata = $urandom(); adata = $urandom();
            tick();
            total++;
            if (dut_out !== model_out()) begin
                bad++; $display("FAIL random cyc=%0d got=%h exp=%h", i, dut_out, model_out());
            end
            if (va === 1'b1 && aa === 1'b1) ovl++;
        end
        total++;
        if (ovl != 0) begin
            bad++; $display("FAIL random_overlap count=%0d exp=0", ovl);
        end
    endtask

    initial begin
        test_reset();
        test_video_only();
        test_round_robin();
        test_early_release();
        test_urgent();
        test_write_gating();
        test_mid_grant_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/zbt_access_arbiter.md
ZBT_ACCESS_ARBITER -- requirements
Module: zbt_access_arbiter

Interface
REQ-001 SHALL have parameter SLOT_LEN, default 16, grant-slot length in clock cycles (even, >= 2).
REQ-002 SHALL have parameter GAP_LEN, default 2, idle cycles between grants to different owners (>= 1).
REQ-003 SHALL use a single clock and an asynchronous, active-low reset: one clock (`clock`); reset (`resetn`) is asynchronous and active-low.
REQ-004 Ports (name, direction, width, meaning):
- clock  in  1  sole clock
- resetn  in  1  asynchronous active-low reset
- Video_Req_I  in  1  video bitstream buffer wants ZBT
- Audio_Req_I  in  1  audio bitstream buffer wants ZBT
- Audio_Urgent_I  in  1  audio output buffer empty (starving)
- Video_ZBT_Access_O  out  1  ZBT_Access to video buffer
- Audio_ZBT_Access_O  out  1  ZBT_Access to audio buffer
- Video_ZBT_Address_I  in  19  video address
- Video_ZBT_Write_Data_I  in  32  video write data
- Video_ZBT_Write_En_I  in  1  video write strobe
- Audio_ZBT_Address_I  in  19  audio address
- Audio_ZBT_Write_Data_I  in  32  audio write data
- Audio_ZBT_Write_En_I  in  1  audio write strobe
- ZBT_Address_O  out  19  to SRAM controller
- ZBT_Write_Data_O  out  32  to SRAM controller
- ZBT_Write_En_O  out  1  to SRAM controller
- Owner_O  out  2  00 none, 01 video, 10 audio

Read data is not routed by this block; it is broadcast to both clients, and each client tags its own reads.

Function
REQ-005 SHALL implement FSM states IDLE, GRANT_VID, GRANT_AUD, GAP, held in a register.
REQ-006 IDLE: if no request, stay in IDLE. Otherwise select a winner (REQ-007), enter GRANT_<winner>, and load slot counter with SLOT_LEN-1.
REQ-007 Selection when both request: round-robin, choosing the requester that is not last_owner. When only one requests, that requester wins.
REQ-008 In GRANT_x, the matching Access_O SHALL be 1 and the other 0. The counter decrements each cycle.
REQ-009 In GRANT_x, when Req_x=0, SHALL go to GAP the next cycle, with the gap counter loaded with GAP_LEN-1 (early release).
REQ-010 In GRANT_x, at counter==0:
- if the other requester is active, go to GAP;
- else if Req_x is still 1, reload the counter with SLOT_LEN-1 and stay in GRANT_x (no gap);
- else go to GAP.
REQ-011 On leaving GRANT_x, last_owner SHALL be set to x.
REQ-012 GAP: both Access_O are 0 and the counter decrements. At 0, apply the REQ-006 decision directly, skipping IDLE.
REQ-013 Mux: Owner_O is 01 in GRANT_VID and 10 in GRANT_AUD; in GAP it holds the previous owner for address/data selection. ZBT_Write_En_O SHALL be the selected client's Write_En ANDed with that client's Access_O, so writes in GAP/IDLE are 0.
REQ-014 In IDLE, ZBT_Address_O, ZBT_Write_Data_O and ZBT_Write_En_O SHALL be 0 and Owner_O SHALL be 00.
REQ-015 Access_O and Owner_O SHALL be registered (FSM-decoded). Address/data mux SHALL be combinational from registered Owner_O (zero-latency pass-through).
REQ-016 Both Access_O SHALL never be 1 in the same cycle.
REQ-017 A request deasserted and reasserted during GAP SHALL be treated as the sampled value at GAP end.

Reset
REQ-018 On resetn=0 the block SHALL asynchronously enter IDLE, with counters 0, last_owner=audio (so video wins the first tie), Access_O both 0, Owner_O 00, and ZBT outputs 0.
REQ-019 A reset asserted mid-grant SHALL drop Access_O in the same reset assertion, with no partial gap.

Configuration
REQ-020 SHALL support macro ZBT_ARB_AUDIO_URGENT_EN.
- Defined: in the REQ-006/012 decision, Audio_Req_I & Audio_Urgent_I SHALL win over round-robin. During GRANT_VID, Audio_Urgent_I & Audio_Req_I SHALL force GAP after at most SLOT_LEN/2 cycles, measured from grant start.
- Undefined: Audio_Urgent_I is ignored and arbitration is pure round-robin.

Verification
REQ-021 Video_Req_I=1 only, SLOT_LEN=16 -> Video_ZBT_Access_O continuously 1 from the 2nd cycle after reset release; no gap at 16-cycle boundaries.
REQ-022 Both requests held from reset -> video granted 16 cycles, 2 gap cycles, audio 16 cycles, 2 gap cycles, repeating; Access_O never overlap.
REQ-023 Audio granted, Audio_Req_I dropped at grant cycle 5 -> GAP at cycle 6 for 2 cycles, then video granted if requesting.
REQ-024 With ZBT_ARB_AUDIO_URGENT_EN, video granted, Audio_Req_I=Audio_Urgent_I=1 at grant cycle 3 -> video grant ends after cycle 8, audio granted after the 2-cycle gap. Without the macro -> video holds the full 16 cycles.
REQ-025 Video_ZBT_Write_En_I=1 with address 0x7FFFF in GAP -> ZBT_Write_En_O=0. During GRANT_VID -> ZBT_Address_O=0x7FFFF and ZBT_Write_En_O=1 in the same cycle.
REQ-026 resetn pulsed low at grant cycle 7 -> Access_O=0, Owner_O=00 immediately; after release, video wins the first tie.
